// File: rtl/ifu_icache_pkg.sv
// Shared types, sizes and address/line field helpers for the IFU instruction cache.
package ifu_icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP
    } state_e;

    localparam int unsigned LINE_BITS  = 128;
    localparam int unsigned BEAT_BITS  = 64;
    localparam int unsigned BEATS      = 2;
    localparam int unsigned INST_BITS  = 32;
    localparam int unsigned WORD_W     = 2;
    localparam int unsigned MAX_ADDR_W = 64;

    // Callers truncate the returned field to their own tag/index width.
    function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned index_w,
                                                       input int unsigned offset_w);
        return addr >> (index_w + offset_w);
    endfunction

    function automatic logic [MAX_ADDR_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned offset_w);
        return addr >> offset_w;
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [MAX_ADDR_W-1:0] addr);
        return addr[3:2];
    endfunction

    function automatic logic [INST_BITS-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                       input logic [WORD_W-1:0] word);
        return INST_BITS'(line >> (32'(word) * INST_BITS));
    endfunction

endpackage

// File: rtl/ifu_icache_refill_buf.sv
// Beat counter and line assembly buffer for a two-beat cache line fill.
module ifu_icache_refill_buf
    import ifu_icache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 beat_valid_i,
    input  logic [BEAT_BITS-1:0] beat_data_i,
    output logic                 last_beat_o,
    output logic [LINE_BITS-1:0] line_o
);

    localparam int unsigned CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LINE_BITS-1:0] line_q, line_d;

    // line_o already contains the beat arriving this cycle.
    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        line_o = line_q;
        line_o[32'(cnt_q) * BEAT_BITS +: BEAT_BITS] = beat_data_i;
        last_beat_o = beat_valid_i && (cnt_q == CNT_W'(BEATS - 1));
        if (start_i) begin
            cnt_d = '0;
        end else if (beat_valid_i) begin
            line_d = line_o;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/ifu_icache_ctrl.sv
// Direct-mapped instruction cache controller: lookup, two-beat refill, fence.i invalidation.
// Define ICACHE_PERF_CNT_EN to add hit/miss performance counter outputs.
module ifu_icache_ctrl
    import ifu_icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned INDEX_WIDTH  = 1,
    parameter int unsigned OFFSET_WIDTH = 4,
    localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [INST_BITS-1:0]    rsp_inst_o,
    input  logic                    fence_i_i,
    output logic [INDEX_WIDTH-1:0]  tag_index_o,
    output logic                    tag_wen_o,
    output logic [TAG_WIDTH-1:0]    tag_wdata_o,
    input  logic [TAG_WIDTH-1:0]    tag_rdata_i,
    output logic [INDEX_WIDTH-1:0]  data_index_o,
    output logic                    data_wen_o,
    output logic [LINE_BITS-1:0]    data_wdata_o,
    input  logic [LINE_BITS-1:0]    data_rdata_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr_o,
    input  logic                    mem_rsp_valid_i,
    input  logic [BEAT_BITS-1:0]    mem_rsp_data_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [63:0]             perf_hit_cnt_o,
    output logic [63:0]             perf_miss_cnt_o
`endif
);

    localparam int unsigned NUM_LINES = 1 << INDEX_WIDTH;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic                   fence_q, fence_d;
    logic [INST_BITS-1:0]   inst_q, inst_d;

    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] idx_q, req_idx;
    logic [WORD_W-1:0]      word_q;
    logic                   hit;
    logic                   req_ready;
    logic                   refill_start;
    logic                   beat_valid;
    logic                   last_beat;
    logic [LINE_BITS-1:0]   fill_line;

    assign tag_q   = TAG_WIDTH'(addr_tag(MAX_ADDR_W'(addr_q), INDEX_WIDTH, OFFSET_WIDTH));
    assign idx_q   = INDEX_WIDTH'(addr_index(MAX_ADDR_W'(addr_q), OFFSET_WIDTH));
    assign word_q  = addr_word(MAX_ADDR_W'(addr_q));
    assign req_idx = INDEX_WIDTH'(addr_index(MAX_ADDR_W'(req_addr_i), OFFSET_WIDTH));
    assign hit     = valid_q[idx_q] && (tag_rdata_i == tag_q);

    // In IDLE the arrays are indexed by the incoming PC so read data lines up with LOOKUP.
    assign tag_index_o    = (state_q == IDLE) ? req_idx : idx_q;
    assign data_index_o   = (state_q == IDLE) ? req_idx : idx_q;
    assign tag_wdata_o    = tag_q;
    assign data_wdata_o   = fill_line;
    assign mem_req_addr_o = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_inst_o     = inst_q;
    assign req_ready_o    = req_ready;

    ifu_icache_refill_buf u_refill_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (refill_start),
        .beat_valid_i (beat_valid),
        .beat_data_i  (mem_rsp_data_i),
        .last_beat_o  (last_beat),
        .line_o       (fill_line)
    );

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        valid_d         = valid_q;
        fence_d         = fence_q | fence_i_i;
        inst_d          = inst_q;
        req_ready       = 1'b0;
        mem_req_valid_o = 1'b0;
        tag_wen_o       = 1'b0;
        data_wen_o      = 1'b0;
        refill_start    = 1'b0;
        beat_valid      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = !fence_q && !fence_i_i;
                if (fence_q) begin
                    // A new pulse arriving while flushing re-arms the flush.
                    valid_d = '0;
                    fence_d = fence_i_i;
                end else if (req_valid_i && req_ready) begin
                    addr_d  = req_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    inst_d  = line_word(data_rdata_i, word_q);
                    state_d = RESP;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    refill_start = 1'b1;
                    state_d      = REFILL;
                end
            end
            REFILL: begin
                beat_valid = mem_rsp_valid_i;
                if (last_beat) begin
                    tag_wen_o      = 1'b1;
                    data_wen_o     = 1'b1;
                    valid_d[idx_q] = 1'b1;
                    inst_d         = line_word(fill_line, word_q);
                    state_d        = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= '0;
            fence_q <= 1'b0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            fence_q <= fence_d;
            inst_q  <= inst_d;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [63:0] hit_cnt_q, miss_cnt_q;

    // Exactly one counter advances per LOOKUP cycle; fence leaves them alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 64'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 64'd1;
            end
        end
    end

    assign perf_hit_cnt_o  = hit_cnt_q;
    assign perf_miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_icache_ctrl.sv
// Randomized self-checking bench for ifu_icache_ctrl against a line-level cache model.
module tb_ifu_icache_ctrl;

    localparam int unsigned AW = 64;
    localparam int unsigned IW = 1;
    localparam int unsigned OW = 4;
    localparam int unsigned TW = AW - IW - OW;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [AW-1:0]  req_addr;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [31:0]    rsp_inst;
    logic           fence_i;
    logic [IW-1:0]  tag_index;
    logic           tag_wen;
    logic [TW-1:0]  tag_wdata;
    logic [TW-1:0]  tag_rdata;
    logic [IW-1:0]  data_index;
    logic           data_wen;
    logic [127:0]   data_wdata;
    logic [127:0]   data_rdata;
    logic           mem_req_valid;
    logic           mem_req_ready;
    logic [AW-1:0]  mem_req_addr;
    logic           mem_rsp_valid;
    logic [63:0]    mem_rsp_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [63:0]    perf_hit_cnt;
    logic [63:0]    perf_miss_cnt;
`endif

    always #5 clk = ~clk;

    ifu_icache_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_inst_o      (rsp_inst),
        .fence_i_i       (fence_i),
        .tag_index_o     (tag_index),
        .tag_wen_o       (tag_wen),
        .tag_wdata_o     (tag_wdata),
        .tag_rdata_i     (tag_rdata),
        .data_index_o    (data_index),
        .data_wen_o      (data_wen),
        .data_wdata_o    (data_wdata),
        .data_rdata_i    (data_rdata),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt_o  (perf_hit_cnt),
        .perf_miss_cnt_o (perf_miss_cnt)
`endif
    );

    // Synchronous-read tag and data SRAMs.
    logic [TW-1:0]  tag_mem  [2];
    logic [127:0]   data_mem [2];

    always @(posedge clk) begin
        if (tag_wen)  tag_mem[tag_index]   <= tag_wdata;
        if (data_wen) data_mem[data_index] <= data_wdata;
        tag_rdata  <= tag_mem[tag_index];
        data_rdata <= data_mem[data_index];
    end

    // Reference model: which line holds which tag and contents.
    bit             m_valid [2];
    logic [TW-1:0]  m_tag   [2];
    logic [127:0]   m_line  [2];
    longint         m_hits;
    longint         m_misses;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] f_tag(input logic [63:0] a);
        return a[63:5];
    endfunction

    function automatic int f_idx(input logic [63:0] a);
        return int'(a[4]);
    endfunction

    function automatic int f_word(input logic [63:0] a);
        return int'(a[3:2]);
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        req_valid     = 1'b0;
        rsp_ready     = 1'b0;
        fence_i       = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_flush();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_ready", 128'(req_ready), 128'(1));
        check_eq("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check_eq("rst_mem_req", 128'(mem_req_valid), 128'(0));
        check_eq("rst_tag_wen", 128'(tag_wen), 128'(0));
        check_eq("rst_data_wen", 128'(data_wen), 128'(0));
        check_eq("rst_rsp_inst", 128'(rsp_inst), 128'(0));
    endtask

    // One complete fetch; hit/miss and the returned word come from the model.
    task automatic fetch(input logic [63:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                         input int rsp_wait, input bit fz_req, input bit fz_refill);
        int           n;
        int           idx;
        bit           exp_hit;
        bit           fenced;
        logic [127:0] line;
        logic [31:0]  exp_inst;
        idx    = f_idx(addr);
        fenced = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        fence_i   = fz_req;
        #1;
        if (fz_req) check_eq("fence_stall", 128'(req_ready), 128'(0));
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            fence_i = 1'b0;
            #1;
            n++;
        end
        fence_i = 1'b0;
        if (fz_req) model_flush();
        if (!req_ready) begin
            check_eq("req_timeout", 128'(0), 128'(1));
            do_reset();
            return;
        end
        exp_hit = m_valid[idx] && (m_tag[idx] == f_tag(addr));
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("lookup_rsp_valid", 128'(rsp_valid), 128'(0));
        if (exp_hit) begin
            m_hits++;
            line = m_line[idx];
            @(negedge clk);
            check_eq("hit_no_mem_req", 128'(mem_req_valid), 128'(0));
            check_eq("hit_latency", 128'(rsp_valid), 128'(1));
        end else begin
            m_misses++;
            line = {b1, b0};
            @(negedge clk);
            check_eq("miss_req", 128'(mem_req_valid), 128'(1));
            if (!mem_req_valid) begin
                do_reset();
                return;
            end
            check_eq("miss_addr", 128'(mem_req_addr), 128'({addr[63:4], 4'h0}));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = b0;
            fence_i       = fz_refill;
            fenced        = fz_refill;
            #1;
            check_eq("beat0_tag_wen", 128'(tag_wen), 128'(0));
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            fence_i       = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = b1;
            #1;
            check_eq("beat1_tag_wen", 128'(tag_wen), 128'(1));
            check_eq("beat1_data_wen", 128'(data_wen), 128'(1));
            check_eq("beat1_tag_wdata", 128'(tag_wdata), 128'(f_tag(addr)));
            check_eq("beat1_data_wdata", data_wdata, line);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            check_eq("refill_rsp_valid", 128'(rsp_valid), 128'(1));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = f_tag(addr);
            m_line[idx]  = line;
        end
        exp_inst = 32'(line >> (32 * f_word(addr)));
        check_eq("rsp_inst", 128'(rsp_inst), 128'(exp_inst));
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", 128'(rsp_valid), 128'(1));
            check_eq("bp_rsp_inst", 128'(rsp_inst), 128'(exp_inst));
            check_eq("bp_req_ready", 128'(req_ready), 128'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_done", 128'(rsp_valid), 128'(0));
        if (fenced) begin
            check_eq("fence_block_ready", 128'(req_ready), 128'(0));
            model_flush();
        end else begin
            check_eq("idle_ready", 128'(req_ready), 128'(1));
        end
    endtask

    task automatic check_perf();
`ifdef ICACHE_PERF_CNT_EN
        check_eq("perf_hits", 128'(perf_hit_cnt), 128'(m_hits));
        check_eq("perf_misses", 128'(perf_miss_cnt), 128'(m_misses));
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] a;
        logic [63:0] base;
        int          sel;
        for (int i = 0; i < 2; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
            m_tag[i]    = '0;
            m_line[i]   = '0;
        end
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        rsp_ready     = 1'b0;
        fence_i       = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        do_reset();
        check_reset_outputs();

        // Cold miss, hit, conflicts.
        fetch(64'h8000_0004, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 1'b0, 1'b0);
        fetch(64'h8000_000C, 64'h0, 64'h0, 0, 1'b0, 1'b0);
        fetch(64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b0);
        fetch(64'h9000_0000, 64'hDEAD_BEEF_0000_1111, 64'h2222_3333_4444_5555, 0, 1'b0, 1'b0);
        fetch(64'h8000_0004, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 1'b0, 1'b0);
        fetch(64'h8000_0014, 64'h0, 64'h0, 1, 1'b0, 1'b0);

        // Fence during refill, then the old line must miss.
        fetch(64'h9000_0008, 64'h0F0F_0F0F_1234_5678, 64'h9ABC_DEF0_F0F0_F0F0, 0, 1'b0, 1'b1);
        fetch(64'h8000_0004, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 1'b0, 1'b0);

        // Response backpressure on a hit.
        fetch(64'h8000_0004, 64'h0, 64'h0, 5, 1'b0, 1'b0);
        fetch(64'h9000_0000, 64'h7777_0000_7777_0000, 64'h8888_1111_8888_1111, 0, 1'b0, 1'b0);

        // Reset after the first beat of a refill.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 64'h8000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_test_mem_req", 128'(mem_req_valid), 128'(1));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hCAFE_CAFE_CAFE_CAFE;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_flush();
        m_hits   = 0;
        m_misses = 0;
        check_reset_outputs();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check_eq("stray_tag_wen", 128'(tag_wen), 128'(0));
        check_eq("stray_data_wen", 128'(data_wen), 128'(0));
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check_eq("stray_rsp_valid", 128'(rsp_valid), 128'(0));
        check_eq("stray_req_ready", 128'(req_ready), 128'(1));
        fetch(64'h9000_0000, 64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210, 0, 1'b0, 1'b0);

        // Randomized traffic over a few competing tags.
        for (int it = 0; it < 200; it++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       base = 64'h8000_0000;
                1:       base = 64'h9000_0000;
                2:       base = 64'hA000_0000;
                default: base = {$urandom, $urandom};
            endcase
            a = {base[63:5], 1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 2'b00};
            fetch(a, {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0));
        end
        check_perf();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_icache_ctrl.md
Name: ifu_icache_ctrl

Overview:
- Direct-mapped instruction-cache controller in the IFU.
- Sits between the fetch stage and the memory bus.
- Drives the icache tag and data SRAM arrays: index, write enable, write data; consumes their synchronous read data.
- Holds the per-line valid bits, detects hit/miss, refills a line from memory in 2 beats, and returns one 32-bit instruction per request.

Parameters:
- ADDR_WIDTH, 64, fetch/memory address width
- INDEX_WIDTH, 1, set-index bits; 2^INDEX_WIDTH lines
- OFFSET_WIDTH, 4, byte offset within a 16-byte line
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (59), derived localparam, not overridable

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  controller accepts request
- req_addr_i  in  ADDR_WIDTH  fetch PC, 4-byte aligned
- rsp_valid_o  out  1  instruction valid
- rsp_ready_i  in  1  fetch consumes instruction
- rsp_inst_o  out  32  instruction
- fence_i_i  in  1  one-cycle pulse: invalidate all lines
- tag_index_o  out  INDEX_WIDTH  tag array index
- tag_wen_o  out  1  tag array write enable, active-high
- tag_wdata_o  out  TAG_WIDTH  tag write data
- tag_rdata_i  in  TAG_WIDTH  tag read data; valid 1 cycle after index
- data_index_o  out  INDEX_WIDTH  data array index
- data_wen_o  out  1  data array write enable
- data_wdata_o  out  128  line write data
- data_rdata_i  in  128  line read data; valid 1 cycle after index
- mem_req_valid_o  out  1  line-fill request
- mem_req_ready_i  in  1  bus accepts request
- mem_req_addr_o  out  ADDR_WIDTH  line-aligned fill address
- mem_rsp_valid_i  in  1  fill beat valid; no backpressure
- mem_rsp_data_i  in  64  fill beat; beat 0 is the low half of the line

Behaviour:
- Reset: state IDLE; all valid bits 0; fence_pending 0; beat count 0.
- Reset output values: req_ready_o 1, rsp_valid_o 0, mem_req_valid_o 0, tag_wen_o 0, data_wen_o 0, rsp_inst_o 0.
- Reset mid-refill aborts the refill. Beats arriving afterwards in IDLE are ignored.
- Address fields: tag = addr[ADDR_WIDTH-1 : INDEX_WIDTH+OFFSET_WIDTH]; index = addr[INDEX_WIDTH+OFFSET_WIDTH-1 : OFFSET_WIDTH]; word = addr[3:2].
- Array index source: in IDLE, tag_index_o and data_index_o take the index of req_addr_i. In all other states they take the latched index.
- req_ready_o = (state==IDLE) and !fence_pending and !fence_i_i.
- IDLE:
  - Handshake latches the address and goes to LOOKUP.
  - If fence_pending, clear all valid bits this cycle, clear fence_pending, accept no request.
  - A fence_i_i pulse in any state sets fence_pending. A fence and a request in the same IDLE cycle: the fence wins, the request stalls.
- LOOKUP: hit = valid[idx] and tag_rdata_i == latched tag.
  - Hit: register data_rdata_i word[word] into rsp_inst_o, go to RESP. Hit latency: request handshake to rsp_valid_o = 2 cycles.
  - Miss: go to MISS_REQ.
- MISS_REQ: mem_req_valid_o=1, mem_req_addr_o = latched addr with offset bits zeroed. On mem_req_ready_i go to REFILL with beat count 0.
- REFILL:
  - Each mem_rsp_valid_i stores a beat into a 128-bit line buffer at half [count] and increments the count.
  - On beat 1, in the same cycle: tag_wen_o=1 with tag_wdata_o = latched tag; data_wen_o=1 with data_wdata_o = {beat1, buffer low}; valid[idx] set; rsp_inst_o = selected word of the assembled line.
  - Then go to RESP.
  - Beats outside REFILL are ignored.
- RESP: rsp_valid_o=1 with rsp_inst_o held stable. On rsp_ready_i go to IDLE. rsp_valid_o never drops without a handshake.
- A fence during a refill does not abort it. The line is written, then invalidated on return to IDLE.
- tag_wen_o and data_wen_o are asserted only in the final REFILL cycle.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hit_cnt_o[63:0] and perf_miss_cnt_o[63:0], both reset to 0.
  - Each LOOKUP cycle increments exactly one counter; the counters wrap at 2^64.
  - Counters are not cleared by fence.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package ifu_icache_pkg:
  - state encoding: IDLE, LOOKUP, MISS_REQ, REFILL, RESP
  - localparams: LINE_BITS=128, BEAT_BITS=64, BEATS=2
  - tag/index/word field-extraction functions
- Sub-module ifu_icache_refill_buf: beat counter plus 128-bit line buffer. It outputs last_beat and the assembled line.

Test Plan:
- Cold miss: reset, request 0x8000_0004 → one mem_req with addr 0x8000_0000. Beats 0x1111_2222_3333_4444, 0x5555_6666_7777_8888 → tag_wen_o pulse; rsp_inst_o 0x1111_2222.
- Hit: then request 0x8000_000C → no mem_req; rsp_valid_o 2 cycles after the handshake; rsp_inst_o 0x5555_6666.
- Conflict: request 0x8000_0010 (index 1) fills line 1. Then 0x9000_0000 (index 0, new tag) → miss and refill; 0x8000_0004 then misses again.
- Fence: fence_i_i pulsed during a REFILL → response is delivered; next IDLE cycle has req_ready_o=0; following request 0x8000_0004 misses.
- Backpressure: hold rsp_ready_i=0 for 5 cycles → rsp_valid_o and rsp_inst_o stable; req_ready_o=0 throughout.
- Reset after beat 0 of a refill → all outputs at reset values next cycle; a subsequent stray beat is ignored; next request misses.
